fifo_rd_checker: RTL and testbench

- Read-side consumer for the team's FIFO. It drains a requested number of bytes through the FIFO read port (r_en/r_data/r_empty) and forwards them as a registered valid stream.
- Each byte is checked against an incrementing pattern, the same 0,1,2,… wrap-around pattern the FIFO write bench produces. Mismatches are counted.
- Sits in the FIFO read clock domain; used in the FIFO loopback bench and in on-board self-test.

---
 rtl/fifo_rd_pkg.sv | 24 ++
 rtl/fifo_rd_checker_rd_lat_pipe.sv | 41 ++++
 rtl/fifo_rd_checker.sv | 162 ++++++++++++++++
 tb/tb_fifo_rd_checker.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// ============================================================================
// Module   : fifo_rd_pkg
// Brief    : Shared state encoding and default parameters for fifo_rd_checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_rd_pkg;

    localparam int C_DATA_W  = 8;
    localparam int C_LEN_W   = 16;
    localparam int C_RD_LAT  = 1;
    localparam int C_TIMEOUT = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

endpackage

`default_nettype wire

// File: rtl/fifo_rd_checker_rd_lat_pipe.sv
// ============================================================================
// Module   : rd_lat_pipe
// Brief    : RD_LAT-deep valid shift register tracking outstanding FIFO reads.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rd_lat_pipe
    import fifo_rd_pkg::*;
#(
    parameter int RD_LAT = C_RD_LAT
) (
    input  logic r_clk,
    input  logic rst_n,
    input  logic vld_in,
    output logic vld_out,
    output logic empty
);

    logic [RD_LAT-1:0] r_pipe;

    generate
        if (RD_LAT == 1) begin : g_single
            always_ff @(posedge r_clk or negedge rst_n) begin
                if (!rst_n) r_pipe <= '0;
                else        r_pipe <= vld_in;
            end
        end else begin : g_multi
            always_ff @(posedge r_clk or negedge rst_n) begin
                if (!rst_n) r_pipe <= '0;
                else        r_pipe <= {r_pipe[RD_LAT-2:0], vld_in};
            end
        end
    endgenerate

    assign vld_out = r_pipe[RD_LAT-1];
    assign empty   = ~|r_pipe;

endmodule

`default_nettype wire

// File: rtl/fifo_rd_checker.sv
// ============================================================================
// Module   : fifo_rd_checker
// Brief    : Drains a burst from the FIFO read port and checks it against an
//            incrementing pattern. Optional starvation abort: FIFO_RD_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rd_checker
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W  = C_DATA_W,
    parameter int LEN_W   = C_LEN_W,
    parameter int RD_LAT  = C_RD_LAT,
    parameter int TIMEOUT = C_TIMEOUT
) (
    input  logic              r_clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic [DATA_W-1:0] seed,
    input  logic              r_empty,
    input  logic [DATA_W-1:0] r_data,
    output logic              r_en,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  rd_cnt,
    output logic [LEN_W-1:0]  err_cnt,
    output logic              timeout
);

    generate
        if (RD_LAT < 1 || RD_LAT > 4 || TIMEOUT < 1) begin : g_param_check
            $error("fifo_rd_checker: RD_LAT must be 1..4 and TIMEOUT >= 1");
        end
    endgenerate

    rd_state_t         r_state;
    rd_state_t         w_state_nxt;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_issued;
    logic [LEN_W-1:0]  w_issued_nxt;
    logic [LEN_W-1:0]  r_rd_cnt;
    logic [LEN_W-1:0]  r_err_cnt;
    logic [DATA_W-1:0] r_expected;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              w_start_acc;
    logic              w_rd_en;
    logic              w_cap;
    logic              w_pipe_empty;
    logic              w_to_hit;

    assign w_start_acc  = (r_state == IDLE) && start;
    assign w_rd_en      = (r_state == READ) && !r_empty && (r_issued < r_len);
    assign w_issued_nxt = r_issued + LEN_W'(w_rd_en);

    rd_lat_pipe #(
        .RD_LAT (RD_LAT)
    ) u_pipe (
        .r_clk   (r_clk),
        .rst_n   (rst_n),
        .vld_in  (w_rd_en),
        .vld_out (w_cap),
        .empty   (w_pipe_empty)
    );

`ifdef FIFO_RD_TIMEOUT_EN
    localparam int C_TO_W = $clog2(TIMEOUT + 1);

    logic [C_TO_W-1:0] r_to_cnt;
    logic              r_timeout;

    assign w_to_hit = (r_state == READ) && r_empty && (r_issued < r_len) &&
                      (r_to_cnt == C_TO_W'(TIMEOUT - 1));

    always_ff @(posedge r_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_start_acc || r_state != READ || !r_empty)
                r_to_cnt <= '0;
            else if (r_issued < r_len)
                r_to_cnt <= r_to_cnt + 1'b1;

            if (w_start_acc)
                r_timeout <= 1'b0;
            else if (w_to_hit)
                r_timeout <= 1'b1;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_to_hit = 1'b0;
    assign timeout  = 1'b0;
`endif

    always_ff @(posedge r_clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = READ;
            READ:    if (w_issued_nxt >= r_len || w_to_hit) w_state_nxt = DRAIN;
            // Every requested byte has left the pipe once it is empty.
            DRAIN:   if (w_pipe_empty) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge r_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len       <= '0;
            r_issued    <= '0;
            r_rd_cnt    <= '0;
            r_err_cnt   <= '0;
            r_expected  <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_cap;
            if (w_cap)
                r_out_data <= r_data;

            if (w_start_acc) begin
                r_len      <= burst_len;
                r_expected <= seed;
                r_issued   <= '0;
                r_rd_cnt   <= '0;
                r_err_cnt  <= '0;
            end else begin
                r_issued <= w_issued_nxt;
                if (w_cap) begin
                    r_rd_cnt   <= r_rd_cnt + 1'b1;
                    // Pattern advances on every byte so one bad byte costs one error.
                    r_expected <= r_expected + 1'b1;
                    if (r_data != r_expected && r_err_cnt != '1)
                        r_err_cnt <= r_err_cnt + 1'b1;
                end
            end
        end
    end

    assign r_en      = w_rd_en;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = (r_state == READ) || (r_state == DRAIN);
    assign done      = (r_state == DONE);
    assign rd_cnt    = r_rd_cnt;
    assign err_cnt   = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_checker.sv
// ============================================================================
// Module   : tb_fifo_rd_checker
// Brief    : Directed bench for fifo_rd_checker with a behavioural FIFO model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_rd_checker;

    localparam int C_DATA_W  = 8;
    localparam int C_LEN_W   = 16;
    localparam int C_RD_LAT  = 1;
    localparam int C_TIMEOUT = 16;

    logic                r_clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic [C_LEN_W-1:0]  burst_len = '0;
    logic [C_DATA_W-1:0] seed = '0;
    logic                r_empty;
    logic [C_DATA_W-1:0] r_data = '0;
    logic                r_en;
    logic                out_valid;
    logic [C_DATA_W-1:0] out_data;
    logic                busy;
    logic                done;
    logic [C_LEN_W-1:0]  rd_cnt;
    logic [C_LEN_W-1:0]  err_cnt;
    logic                timeout;

    always #5 r_clk = ~r_clk;

    fifo_rd_checker #(
        .DATA_W  (C_DATA_W),
        .LEN_W   (C_LEN_W),
        .RD_LAT  (C_RD_LAT),
        .TIMEOUT (C_TIMEOUT)
    ) dut (
        .r_clk     (r_clk),
        .rst_n     (rst_n),
        .start     (start),
        .burst_len (burst_len),
        .seed      (seed),
        .r_empty   (r_empty),
        .r_data    (r_data),
        .r_en      (r_en),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .rd_cnt    (rd_cnt),
        .err_cnt   (err_cnt),
        .timeout   (timeout)
    );

    // Behavioural FIFO with one cycle of read latency.
    logic [7:0] mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign r_empty = (wr_ptr == rd_ptr);

    always @(posedge r_clk) begin
        if (r_en) begin
            r_data <= mem[rd_ptr % 1024];
            rd_ptr <= rd_ptr + 1;
        end
    end

    // Free-running monitor counters; tests compare deltas.
    int ren_n = 0, ovr_n = 0, done_n = 0, cap_n = 0;
    logic [7:0] cap [0:1023];

    always @(negedge r_clk) begin
        if (r_en)            ren_n <= ren_n + 1;
        if (r_en && r_empty) ovr_n <= ovr_n + 1;
        if (done)            done_n <= done_n + 1;
        if (out_valid) begin
            cap[cap_n % 1024] <= out_data;
            cap_n <= cap_n + 1;
        end
    end

    typedef struct {
        int len;
        int seed;
        int fill_base;
        int gap;
        int bad_idx;
        int exp_err;
    } vec_t;

    vec_t vecs [5];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] fill_val(input vec_t vc, input int i);
        if (i == vc.bad_idx) return 8'hFF;
        return 8'(vc.fill_base + i);
    endfunction

    task automatic push_byte(input logic [7:0] b);
        mem[wr_ptr % 1024] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic pulse_start(input int len, input int sd);
        burst_len = C_LEN_W'(len);
        seed      = C_DATA_W'(sd);
        @(negedge r_clk) start = 1'b1;
        @(negedge r_clk) start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit got);
        got = 1'b0;
        for (int c = 0; c < limit; c++) begin
            @(negedge r_clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t vc, input string tag);
        int ren0, ovr0, done0, cap0, bad;
        bit got;
        ren0 = ren_n; ovr0 = ovr_n; done0 = done_n; cap0 = cap_n;
        if (vc.gap == 0)
            for (int i = 0; i < vc.len; i++) push_byte(fill_val(vc, i));
        pulse_start(vc.len, vc.seed);
        fork
            if (vc.gap > 0) begin
                for (int i = 0; i < vc.len; i++) begin
                    repeat (vc.gap) @(posedge r_clk);
                    #2 push_byte(fill_val(vc, i));
                end
            end
            wait_done(3000, got);
        join
        chk({tag, ".done_seen"}, 32'(got), 1);
        repeat (3) @(negedge r_clk);
        bad = 0;
        for (int i = 0; i < vc.len; i++)
            if (cap[(cap0 + i) % 1024] !== fill_val(vc, i)) bad++;
        chk({tag, ".rd_cnt"},    32'(rd_cnt), vc.len);
        chk({tag, ".err_cnt"},   32'(err_cnt), vc.exp_err);
        chk({tag, ".ren_count"}, ren_n - ren0, vc.len);
        chk({tag, ".overread"},  ovr_n - ovr0, 0);
        chk({tag, ".done_cnt"},  done_n - done0, 1);
        chk({tag, ".captured"},  cap_n - cap0, vc.len);
        chk({tag, ".stream"},    bad, 0);
        chk({tag, ".busy_low"},  32'(busy), 0);
    endtask

    initial begin : main
        int ren0, done0;
        bit got;

        //         len  seed   base   gap bad exp_err
        vecs[0] = '{258, 0,     0,     0, -1, 0};  // full wrap 0..255,0,1
        vecs[1] = '{20,  8'h30, 8'h30, 3, -1, 0};  // slow producer
        vecs[2] = '{16,  0,     0,     0, 10, 1};  // byte 10 corrupted
        vecs[3] = '{5,   8'hFE, 8'hFE, 0, -1, 0};  // pattern wraps FF -> 00
        vecs[4] = '{4,   1,     0,     1, -1, 4};  // whole stream off by one

        repeat (3) @(negedge r_clk);
        chk("rst.r_en",      32'(r_en), 0);
        chk("rst.busy",      32'(busy), 0);
        chk("rst.done",      32'(done), 0);
        chk("rst.out_valid", 32'(out_valid), 0);
        chk("rst.out_data",  32'(out_data), 0);
        chk("rst.rd_cnt",    32'(rd_cnt), 0);
        chk("rst.err_cnt",   32'(err_cnt), 0);
        chk("rst.timeout",   32'(timeout), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge r_clk);

        for (int v = 0; v < 5; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

        // Zero-length burst: done exactly three cycles after start.
        ren0 = ren_n;
        burst_len = '0;
        @(negedge r_clk) start = 1'b1;
        @(negedge r_clk) start = 1'b0;
        chk("len0.busy_c1", 32'(busy), 1);
        chk("len0.done_c1", 32'(done), 0);
        @(negedge r_clk);
        chk("len0.done_c2", 32'(done), 0);
        @(negedge r_clk);
        chk("len0.done_c3", 32'(done), 1);
        repeat (2) @(negedge r_clk);
        chk("len0.rd_cnt", 32'(rd_cnt), 0);
        chk("len0.ren",    ren_n - ren0, 0);

        // Start pulsed while busy must be ignored.
        done0 = done_n;
        pulse_start(6, 8'h40);
        repeat (2) @(negedge r_clk);
        chk("ign.busy", 32'(busy), 1);
        burst_len = 16'd2;
        seed      = 8'h00;
        start     = 1'b1;
        @(negedge r_clk) start = 1'b0;
        for (int i = 0; i < 6; i++) push_byte(8'(8'h40 + i));
        wait_done(200, got);
        chk("ign.done_seen", 32'(got), 1);
        repeat (10) @(negedge r_clk);
        chk("ign.rd_cnt",   32'(rd_cnt), 6);
        chk("ign.err_cnt",  32'(err_cnt), 0);
        chk("ign.done_cnt", done_n - done0, 1);

        // Asynchronous reset in the middle of a long burst.
        ren0 = ren_n;
        for (int i = 0; i < 258; i++) push_byte(8'(i));
        pulse_start(258, 0);
        got = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge r_clk);
            if (ren_n - ren0 >= 100) begin
                got = 1'b1;
                break;
            end
        end
        chk("arst.reached_100", 32'(got), 1);
        rst_n = 1'b0;
        #1;
        chk("arst.r_en",      32'(r_en), 0);
        chk("arst.busy",      32'(busy), 0);
        chk("arst.out_valid", 32'(out_valid), 0);
        chk("arst.rd_cnt",    32'(rd_cnt), 0);
        chk("arst.err_cnt",   32'(err_cnt), 0);
        @(negedge r_clk) rst_n = 1'b1;
        wr_ptr = rd_ptr;
        repeat (2) @(negedge r_clk);
        run_vec('{10, 5, 5, 0, -1, 0}, "post_rst");

        // Starvation: FIFO holds 5 bytes of a 10-byte burst.
        done0 = done_n;
        for (int i = 0; i < 5; i++) push_byte(8'(i));
        pulse_start(10, 0);
`ifdef FIFO_RD_TIMEOUT_EN
        wait_done(200, got);
        chk("starve.done_seen", 32'(got), 1);
        repeat (2) @(negedge r_clk);
        chk("starve.timeout", 32'(timeout), 1);
        chk("starve.rd_cnt",  32'(rd_cnt), 5);
        chk("starve.err_cnt", 32'(err_cnt), 0);
        chk("starve.busy",    32'(busy), 0);
`else
        repeat (100) @(negedge r_clk);
        chk("starve.busy",     32'(busy), 1);
        chk("starve.rd_cnt",   32'(rd_cnt), 5);
        chk("starve.no_done",  done_n - done0, 0);
        chk("starve.timeout",  32'(timeout), 0);
        rst_n = 1'b0;
        @(negedge r_clk) rst_n = 1'b1;
`endif

        repeat (2) @(negedge r_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
